// File: rtl/nios_base_sysid_arbiter.sv
// nios_base_sysid_arbiter
// Shares the system-ID slave (word 0 = ID, word 1 = build timestamp) between
// two Avalon-MM read masters. After reset, and when recheck is pulsed in IDLE,
// it reads both words itself and compares them against build-time constants.
// It then arbitrates reads round-robin, one outstanding transaction at a time.

module nios_base_sysid_arbiter #(
   parameter int unsigned READ_LATENCY = 0,            // legal range 0..3
   parameter logic [31:0] EXPECTED_ID  = 32'h38D8FF5B,
   parameter logic [31:0] EXPECTED_TS  = 32'h4E57F59F
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        recheck,
   // requester 0
   input  logic        r0_read,
   input  logic        r0_address,
   output logic        r0_waitrequest,
   output logic        r0_readdatavalid,
   output logic [31:0] r0_readdata,
   // requester 1
   input  logic        r1_read,
   input  logic        r1_address,
   output logic        r1_waitrequest,
   output logic        r1_readdatavalid,
   output logic [31:0] r1_readdata,
   // system-ID slave
   output logic        sys_address,
   input  logic [31:0] sys_readdata,
   // self-check status
   output logic        check_done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [1:0] {
      CHK_ID = 2'd0,
      CHK_TS = 2'd1,
      IDLE   = 2'd2,
      BUSY   = 2'd3
   } state_e;

   localparam logic [1:0] LAT = READ_LATENCY[1:0];

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        sys_address_q, sys_address_d;
   logic        rr_q, rr_d;          // 1 = r1 is favoured when both request
   logic        owner_q, owner_d;    // requester that owns the BUSY transaction
   logic [31:0] r0_readdata_q, r0_readdata_d;
   logic [31:0] r1_readdata_q, r1_readdata_d;
   logic        r0_rdv_q, r0_rdv_d;
   logic        r1_rdv_q, r1_rdv_d;
   logic        check_done_q, check_done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic        gnt0, gnt1;
   logic        elig0, elig1;
   logic        sample;

   assign sample = (cnt_q == LAT);

   // Arbitration: grants exist only in IDLE when no recheck is pending. A
   // requester whose readdatavalid is showing this cycle is not eligible, so
   // its valid pulse never coincides with its own next accept.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      elig0 = r0_read && !r0_rdv_q;
      elig1 = r1_read && !r1_rdv_q;
      if (!reset && (state_q == IDLE) && !recheck) begin
         if (elig0 && !elig1) begin
            gnt0 = 1'b1;
         end else if (elig1 && !elig0) begin
            gnt1 = 1'b1;
         end else if (elig0 && elig1) begin
            gnt0 = !rr_q;
            gnt1 = rr_q;
         end
      end
   end

   assign r0_waitrequest = !gnt0;
   assign r1_waitrequest = !gnt1;

   // Next-state and datapath: self-check sequencing, accept and sampling.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      sys_address_d = sys_address_q;
      rr_d          = rr_q;
      owner_d       = owner_q;
      r0_readdata_d = r0_readdata_q;
      r1_readdata_d = r1_readdata_q;
      r0_rdv_d      = 1'b0;
      r1_rdv_d      = 1'b0;
      check_done_d  = check_done_q;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      id_value_d    = id_value_q;
      ts_value_d    = ts_value_q;

      case (state_q)
         CHK_ID: begin
            if (sample) begin
               id_value_d    = sys_readdata;
               sys_address_d = 1'b1;
               cnt_d         = 2'd0;
               state_d       = CHK_TS;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         CHK_TS: begin
            if (sample) begin
               ts_value_d   = sys_readdata;
               id_ok_d      = (id_value_q == EXPECTED_ID);
               ts_ok_d      = (sys_readdata == EXPECTED_TS);
               check_done_d = 1'b1;
               cnt_d        = 2'd0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         IDLE: begin
            if (recheck) begin
               check_done_d  = 1'b0;
               id_ok_d       = 1'b0;
               ts_ok_d       = 1'b0;
               sys_address_d = 1'b0;
               cnt_d         = 2'd0;
               state_d       = CHK_ID;
            end else if (gnt0 || gnt1) begin
               sys_address_d = gnt1 ? r1_address : r0_address;
               owner_d       = gnt1;
               rr_d          = gnt0;   // favour the requester not just served
               cnt_d         = 2'd0;
               state_d       = BUSY;
            end
         end

         BUSY: begin
            if (sample) begin
               if (owner_q) begin
                  r1_readdata_d = sys_readdata;
                  r1_rdv_d      = 1'b1;
               end else begin
                  r0_readdata_d = sys_readdata;
                  r0_rdv_d      = 1'b1;
               end
               cnt_d   = 2'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         default: state_d = CHK_ID;
      endcase
   end

   // State register with synchronous reset; reset aborts any transaction.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
      if (reset) begin
         state_q       <= CHK_ID;
         cnt_q         <= 2'd0;
         sys_address_q <= 1'b0;
         rr_q          <= 1'b0;
         owner_q       <= 1'b0;
         r0_readdata_q <= '0;
         r1_readdata_q <= '0;
         r0_rdv_q      <= 1'b0;
         r1_rdv_q      <= 1'b0;
         check_done_q  <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         id_value_q    <= '0;
         ts_value_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sys_address_q <= sys_address_d;
         rr_q          <= rr_d;
         owner_q       <= owner_d;
         r0_readdata_q <= r0_readdata_d;
         r1_readdata_q <= r1_readdata_d;
         r0_rdv_q      <= r0_rdv_d;
         r1_rdv_q      <= r1_rdv_d;
         check_done_q  <= check_done_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
      end
   end

   assign sys_address      = sys_address_q;
   assign r0_readdata      = r0_readdata_q;
   assign r1_readdata      = r1_readdata_q;
   assign r0_readdatavalid = r0_rdv_q;
   assign r1_readdatavalid = r1_rdv_q;
   assign check_done       = check_done_q;
   assign id_ok            = id_ok_q;
   assign ts_ok            = ts_ok_q;
   assign id_value         = id_value_q;
   assign ts_value         = ts_value_q;

endmodule

// File: tb/tb_nios_base_sysid_arbiter.sv
// Bench for nios_base_sysid_arbiter: three instances at READ_LATENCY 0, 2, 3.
// Reads on the L=2 instance go through a scoreboard filled at accept time and
// drained when readdatavalid appears.

module tb_nios_base_sysid_arbiter;

   localparam logic [31:0] EXP_ID = 32'h38D8FF5B;
   localparam logic [31:0] EXP_TS = 32'h4E57F59F;
   localparam int          ML     = 2;   // latency of the main instance

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- instance A: READ_LATENCY = 0 ----------------
   logic        a_reset, a_r0_wait, a_r1_wait, a_r0_rdv, a_r1_rdv, a_sys_address;
   logic        a_done, a_id_ok, a_ts_ok;
   logic [31:0] a_r0_rdata, a_r1_rdata, a_id_value, a_ts_value, a_sys_rdata;
   assign a_sys_rdata = a_sys_address ? EXP_TS : EXP_ID;

   nios_base_sysid_arbiter #(.READ_LATENCY(0)) u_l0 (
      .clock(clock), .reset(a_reset), .recheck(1'b0),
      .r0_read(1'b0), .r0_address(1'b0), .r0_waitrequest(a_r0_wait),
      .r0_readdatavalid(a_r0_rdv), .r0_readdata(a_r0_rdata),
      .r1_read(1'b0), .r1_address(1'b0), .r1_waitrequest(a_r1_wait),
      .r1_readdatavalid(a_r1_rdv), .r1_readdata(a_r1_rdata),
      .sys_address(a_sys_address), .sys_readdata(a_sys_rdata),
      .check_done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
      .id_value(a_id_value), .ts_value(a_ts_value));

   // ---------------- instance B: READ_LATENCY = 3 ----------------
   logic        b_reset, b_r0_read, b_r0_address;
   logic        b_r0_wait, b_r1_wait, b_r0_rdv, b_r1_rdv, b_sys_address;
   logic        b_done, b_id_ok, b_ts_ok;
   logic [31:0] b_r0_rdata, b_r1_rdata, b_id_value, b_ts_value, b_sys_rdata;
   assign b_sys_rdata = b_sys_address ? EXP_TS : EXP_ID;
   int b_rdv_cnt = 0;
   always @(negedge clock) if (b_r0_rdv || b_r1_rdv) b_rdv_cnt++;

   nios_base_sysid_arbiter #(.READ_LATENCY(3)) u_l3 (
      .clock(clock), .reset(b_reset), .recheck(1'b0),
      .r0_read(b_r0_read), .r0_address(b_r0_address), .r0_waitrequest(b_r0_wait),
      .r0_readdatavalid(b_r0_rdv), .r0_readdata(b_r0_rdata),
      .r1_read(1'b0), .r1_address(1'b0), .r1_waitrequest(b_r1_wait),
      .r1_readdatavalid(b_r1_rdv), .r1_readdata(b_r1_rdata),
      .sys_address(b_sys_address), .sys_readdata(b_sys_rdata),
      .check_done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
      .id_value(b_id_value), .ts_value(b_ts_value));

   // ---------------- main instance M: READ_LATENCY = 2 ----------------
   logic        m_reset, m_recheck, m_r0_read, m_r0_address, m_r1_read, m_r1_address;
   logic        m_r0_wait, m_r1_wait, m_r0_rdv, m_r1_rdv, m_sys_address;
   logic        m_done, m_id_ok, m_ts_ok;
   logic [31:0] m_r0_rdata, m_r1_rdata, m_id_value, m_ts_value, m_sys_rdata;
   logic [31:0] m_id_word, m_ts_word;
   assign m_sys_rdata = m_sys_address ? m_ts_word : m_id_word;

   nios_base_sysid_arbiter #(.READ_LATENCY(ML)) u_main (
      .clock(clock), .reset(m_reset), .recheck(m_recheck),
      .r0_read(m_r0_read), .r0_address(m_r0_address), .r0_waitrequest(m_r0_wait),
      .r0_readdatavalid(m_r0_rdv), .r0_readdata(m_r0_rdata),
      .r1_read(m_r1_read), .r1_address(m_r1_address), .r1_waitrequest(m_r1_wait),
      .r1_readdatavalid(m_r1_rdv), .r1_readdata(m_r1_rdata),
      .sys_address(m_sys_address), .sys_readdata(m_sys_rdata),
      .check_done(m_done), .id_ok(m_id_ok), .ts_ok(m_ts_ok),
      .id_value(m_id_value), .ts_value(m_ts_value));

   // ---------------- scoreboard for the main instance ----------------
   typedef struct {
      bit          req;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int n_acc = 0, n_rdv = 0, alt_n = 0, last_cyc = 0;
   bit last_req = 1'b0, alt_mode = 1'b0, alt_prev = 1'b0;

   always @(negedge clock) begin
      bit   acc0, acc1, req, a;
      exp_t e;
      acc0 = m_r0_read && !m_r0_wait;
      acc1 = m_r1_read && !m_r1_wait;
      if (m_r0_rdv || m_r1_rdv) begin
         n_rdv++;
         check("rdv_onehot", 32'(m_r0_rdv & m_r1_rdv), 0);
         if (sb.size() == 0) begin
            check("rdv_unexpected", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check("rdv_owner", 32'(m_r1_rdv), 32'(e.req));
            check("rdv_data", e.req ? m_r1_rdata : m_r0_rdata, e.data);
            check("rdv_cycle", cyc, e.cyc);
         end
      end
      if (acc0 || acc1) begin
         check("accept_onehot", 32'(acc0 & acc1), 0);
         req = acc1;
         a   = req ? m_r1_address : m_r0_address;
         e.req  = req;
         e.data = a ? m_ts_word : m_id_word;
         e.cyc  = cyc + ML + 2;
         sb.push_back(e);
         n_acc++;
         if (alt_mode) begin
            alt_n++;
            check("alt_req", 32'(req), 32'(!last_req));
            if (alt_prev) check("alt_gap", cyc - last_cyc, ML + 2);
            alt_prev = 1'b1;
         end
         last_req = req;
         last_cyc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int done_cyc;
      a_reset = 1'b1; b_reset = 1'b1; m_reset = 1'b1;
      b_r0_read = 1'b0; b_r0_address = 1'b0;
      m_recheck = 1'b0; m_r0_read = 1'b0; m_r0_address = 1'b0;
      m_r1_read = 1'b0; m_r1_address = 1'b0;
      m_id_word = EXP_ID; m_ts_word = 32'h0;
      repeat (3) @(posedge clock);

      // Reset state of the main instance while reset is held.
      @(negedge clock);
      check("rst_r0_wait", 32'(m_r0_wait), 1);
      check("rst_r1_wait", 32'(m_r1_wait), 1);
      check("rst_done", 32'(m_done), 0);
      check("rst_sys_addr", 32'(m_sys_address), 0);
      check("rst_id_value", m_id_value, 0);
      check("rst_rdv", 32'(m_r0_rdv | m_r1_rdv), 0);

      // L=0 self-check timing.
      @(posedge clock); #1 a_reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (c < 2) begin
            check($sformatf("l0_r0_wait_c%0d", c), 32'(a_r0_wait), 1);
            check($sformatf("l0_r1_wait_c%0d", c), 32'(a_r1_wait), 1);
            check($sformatf("l0_done_c%0d", c), 32'(a_done), 0);
         end else begin
            check("l0_done_c2", 32'(a_done), 1);
            check("l0_id_ok", 32'(a_id_ok), 1);
            check("l0_ts_ok", 32'(a_ts_ok), 1);
            check("l0_id_value", a_id_value, EXP_ID);
         end
      end

      // L=3: reset during BUSY.
      @(posedge clock); #1 b_reset = 1'b0;
      k = 0;
      while (!b_done && k < 20) begin @(negedge clock); k++; end
      check("l3_first_done", 32'(b_done), 1);
      @(posedge clock); #1 b_r0_address = 1'b1; b_r0_read = 1'b1;
      @(negedge clock);
      check("l3_accept", 32'(b_r0_wait), 0);
      @(posedge clock); #1 b_r0_read = 1'b0;
      @(posedge clock); #1 b_reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("l3_rst_rdata", b_r0_rdata, 0);
      check("l3_rst_sys_addr", 32'(b_sys_address), 0);
      check("l3_rst_done", 32'(b_done), 0);
      check("l3_rst_ok", 32'({b_id_ok, b_ts_ok}), 0);
      check("l3_rst_values", b_id_value | b_ts_value, 0);
      check("l3_rst_wait", 32'(b_r0_wait & b_r1_wait), 1);
      @(posedge clock); #1 b_reset = 1'b0;
      k = 0; done_cyc = -1;
      while (k < 20 && done_cyc < 0) begin
         @(negedge clock);
         if (b_done) done_cyc = k;
         k++;
      end
      check("l3_redone_cycle", done_cyc, 8);
      check("l3_id_ok", 32'(b_id_ok), 1);
      check("l3_no_rdv", b_rdv_cnt, 0);

      // Main: ts word forced to zero, r0 pulses read during CHK_TS only.
      @(posedge clock); #1 m_reset = 1'b0;
      k = 0; done_cyc = -1;
      while (k < 30 && done_cyc < 0) begin
         m_r0_read = (k == 2 * ML - 1) || (k == 2 * ML);
         @(negedge clock);
         if (m_r0_read) check("chk_ts_r0_wait", 32'(m_r0_wait), 1);
         if (m_done) done_cyc = k;
         @(posedge clock); #1;
         k++;
      end
      m_r0_read = 1'b0;
      check("m_done_cycle", done_cyc, 2 * ML + 2);
      check("m_id_ok", 32'(m_id_ok), 1);
      check("m_ts_ok_zero", 32'(m_ts_ok), 0);
      check("m_ts_value_zero", m_ts_value, 0);
      check("m_id_value", m_id_value, EXP_ID);
      repeat (3) @(posedge clock);
      #1;
      check("chk_ts_no_accept", n_acc, 0);
      check("chk_ts_no_rdv", n_rdv, 0);

      // Recheck in IDLE together with r1_read.
      m_ts_word = EXP_TS;
      m_recheck = 1'b1; m_r1_read = 1'b1; m_r1_address = 1'b1;
      @(negedge clock);
      check("recheck_r1_wait", 32'(m_r1_wait), 1);
      @(posedge clock); #1 m_recheck = 1'b0;
      @(negedge clock);
      check("recheck_done_drop", 32'(m_done), 0);
      k = 0;
      while (k < 30 && !m_done) begin @(negedge clock); k++; end
      check("recheck_done_gap", k, 2 * ML + 2);
      check("recheck_ts_ok", 32'(m_ts_ok), 1);
      check("recheck_id_ok", 32'(m_id_ok), 1);
      k = 0;
      while (k < 30 && n_acc == 0) begin @(negedge clock); #1; k++; end
      check("r1_granted", n_acc, 1);
      check("r1_first", 32'(last_req), 1);
      @(posedge clock); #1 m_r1_read = 1'b0;
      k = 0;
      while (k < 30 && sb.size() != 0) begin @(negedge clock); #1; k++; end
      check("r1_drain", sb.size(), 0);

      // Both requesters read continuously: grants must alternate.
      @(posedge clock); #1;
      alt_mode = 1'b1;
      m_r0_read = 1'b1; m_r0_address = 1'b0;
      m_r1_read = 1'b1; m_r1_address = 1'b1;
      repeat (40) @(posedge clock);
      #1 m_r0_read = 1'b0; m_r1_read = 1'b0;
      k = 0;
      while (k < 30 && sb.size() != 0) begin @(negedge clock); #1; k++; end
      check("alt_accepts", alt_n, 10);
      check("sb_empty", sb.size(), 0);
      check("rdv_total", n_rdv, n_acc);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/nios_base_sysid_arbiter.md
# nios_base_sysid_arbiter

Shares the 32-bit system-ID control slave (word 0 = system ID, word 1 = build timestamp, combinational read data) between two Avalon-MM read masters, the host-bridge path and the Nios debug path. After every reset, and on demand, it first reads both words itself and compares them against build-time expected values. It sits between the requesters and the system-ID slave and is the only block that drives the slave's address.

## Interface
- READ_LATENCY, 0: cycles the slave needs after its address becomes stable before read data is sampled; legal range 0–3.
- EXPECTED_ID, 32'h38D8FF5B: expected word 0.
- EXPECTED_TS, 32'h4E57F59F: expected word 1.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- recheck  in  1  single-cycle request to re-run the self-check; honoured only in IDLE.
- r0_read  in  1  requester 0 read strobe.
- r0_address  in  1  requester 0 word select.
- r0_waitrequest  out  1  high = request not accepted this cycle.
- r0_readdatavalid  out  1  one-cycle pulse marking r0_readdata valid.
- r0_readdata  out  32  requester 0 read data.
- r1_read, r1_address, r1_waitrequest, r1_readdatavalid, r1_readdata: same as r0_*, for requester 1.
- sys_address  out  1  registered address to the system-ID slave.
- sys_readdata  in  32  system-ID slave read data.
- check_done  out  1  high once a self-check has completed; cleared when a new check starts.
- id_ok  out  1  captured word 0 == EXPECTED_ID.
- ts_ok  out  1  captured word 1 == EXPECTED_TS.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

## Operation
- States: CHK_ID, CHK_TS, IDLE, BUSY.
- Reset values:
  - state = CHK_ID, latency counter = 0, sys_address = 0.
  - All r*_readdata, id_value and ts_value = 0.
  - r*_readdatavalid, check_done, id_ok and ts_ok = 0.
  - Round-robin pointer favours r0.
- r*_waitrequest are combinational from state and grant. Both are high in CHK_ID, CHK_TS and BUSY, and during reset.
- CHK_ID:
  - sys_address = 0.
  - On the edge where counter == READ_LATENCY: capture sys_readdata into id_value, set sys_address ← 1, clear counter, go to CHK_TS.
  - Otherwise the counter increments.
- CHK_TS:
  - Same counting rule; on the sample edge, capture into ts_value.
  - Register id_ok and ts_ok, set check_done = 1, go to IDLE.
- IDLE, evaluated in priority order:
  - If recheck = 1: clear check_done, id_ok and ts_ok; set sys_address ← 0; go to CHK_ID. No grant is issued this cycle, so both waitrequests stay high.
  - Else, with exactly one r*_read high: grant that requester.
  - Else, with both high: grant the requester not served last; the pointer flips after each grant.
  - The granted requester sees waitrequest = 0 for that cycle, which is the accept cycle. The other stays high.
  - On accept: latch the requester's address into sys_address, record the owner, clear the counter, go to BUSY.
- BUSY:
  - On the edge where counter == READ_LATENCY: capture sys_readdata into the owner's r*_readdata, pulse the owner's r*_readdatavalid in the next cycle, return to IDLE.
- Non-owner r*_readdata holds its value. sys_address holds its last value in IDLE.
- A requester dropping read while waitrequest is high produces no transaction. This is legal.
- recheck outside IDLE is ignored; it is not queued.
- Reset in any state aborts the operation: no readdatavalid is issued and the self-check restarts.

## Timing
- Self-check after reset release, with L = READ_LATENCY:
  - CHK_ID occupies cycles 0..L.
  - CHK_TS occupies cycles L+1..2L+1.
  - check_done rises in cycle 2L+2, which is the first IDLE cycle.
- Read with accept in cycle A:
  - sys_address is valid from A+1.
  - Sample occurs at the end of cycle A+1+L.
  - r*_readdatavalid is high in cycle A+2+L.
  - That cycle is IDLE and may accept the next request. Peak throughput is one read per L+2 cycles.
- readdatavalid is exactly one cycle wide and never overlaps an accept for the same requester's next transaction.

## Test plan
- Reset release, L=0, slave returning 32'h38D8FF5B / 32'h4E57F59F: check_done rises in cycle 2, id_ok = ts_ok = 1, and both waitrequests are high in cycles 0–1.
- Slave word 1 forced to 32'h00000000: ts_ok = 0, id_ok = 1, ts_value = 0.
- r0 and r1 read continuously (addresses 0 and 1), L=2: grants alternate r0, r1, r0…, each readdatavalid arrives 4 cycles after its accept with the correct word, and there is one accept every 4 cycles.
- A recheck pulse in IDLE concurrent with r1_read: r1_waitrequest stays high, check_done drops, then re-asserts after 2L+2 cycles, and r1 is granted afterwards.
- reset asserted during BUSY (L=3): no readdatavalid is issued, all outputs return to reset values, and the self-check restarts.
- r0 raises read during CHK_TS, then drops it before IDLE: no accept and no readdatavalid.
